// File: rtl/sssp_update_packer_pkg.sv
// Shared types and constants for the SSSP update packer: update word layout, padding word,
// control code for update beats, FSM state encodings and the partial-line padding helper.
package sssp_update_packer_pkg;

    typedef struct packed {
        logic [31:0] weight;
        logic [31:0] dst;
    } update_t;

    localparam int SSSP_UPDATES_PER_LINE = 8;

    typedef update_t [SSSP_UPDATES_PER_LINE-1:0] line_t;

    localparam update_t    SSSP_PAD_WORD    = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [1:0] SSSP_CTRL_UPDATE = 2'h2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ACCUM = 3'd1;
    localparam logic [2:0] ST_FLUSH = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Slots at or above the fill level carry the pad word so the host can skip them.
    function automatic line_t pad_line(input line_t line, input logic [2:0] fill);
        line_t res;
        for (int k = 0; k < SSSP_UPDATES_PER_LINE; k++) begin
            if (3'(k) < fill) begin
                res[k] = line[k];
            end else begin
                res[k] = SSSP_PAD_WORD;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sssp_update_packer_line_fifo.sv
// Synchronous show-ahead line FIFO: the head entry is visible on rd_data whenever not empty.
// rd_data reads as zero while empty so the packed-line output is clean out of reset.
module sssp_line_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 512,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_wr_s, do_rd_s;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == {CW{1'b0}});
    assign count   = count_q;
    assign rd_data = empty ? {WIDTH{1'b0}} : mem_q[rptr_q];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    always_comb begin
        do_rd_s = rd_en && !empty;
        do_wr_s = wr_en && (!full || do_rd_s);
        wptr_d  = do_wr_s ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = do_rd_s ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q + CW'(do_wr_s) - CW'(do_rd_s);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= {AW{1'b0}};
            rptr_q  <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/sssp_update_packer.sv
// Packs per-lane {weight,dst} relax updates into 512-bit write-back lines, flushing a padded
// partial line on last_input. Optional counters lines_out/pad_slots under SSSP_PACKER_STATS_EN.
module sssp_update_packer
    import sssp_update_packer_pkg::*;
#(
    parameter int LANES        = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          control_in,
    input  logic [LANES-1:0]    lane_valid,
    input  logic [64*LANES-1:0] lane_word,
    input  logic                last_input_in,
    output logic [511:0]        out_line,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                almost_full,
    output logic                done,
    output logic [31:0]         update_count,
`ifdef SSSP_PACKER_STATS_EN
    output logic [31:0]         lines_out,
    output logic [31:0]         pad_slots,
`endif
    output logic                err_overflow,
    output logic                err_proto
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]  state_q, state_d;
    logic [2:0]  fill_q, fill_d;
    line_t       acc_q, acc_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_ov_q, err_ov_d;
    logic        err_pr_q, err_pr_d;
    logic        done_q, done_d;

    line_t       cur_s, nxt_s, push_line_s;
    logic        accept_s, complete_s, push_s, pop_s, push_ok_s;
    logic [3:0]  rank_s, pos_s, sum_s;
    logic        fifo_full_s, fifo_empty_s;
    logic [CW-1:0] fifo_count_s;

    // Compact valid lanes in ascending order; positions past slot 7 spill into the next line.
    always_comb begin
        accept_s = (control_in == SSSP_CTRL_UPDATE) &&
                   ((state_q == ST_IDLE) || (state_q == ST_ACCUM));
        cur_s    = acc_q;
        nxt_s    = acc_q;
        rank_s   = 4'd0;
        pos_s    = 4'd0;
        for (int i = 0; i < LANES; i++) begin
            if (accept_s && lane_valid[i]) begin
                pos_s = {1'b0, fill_q} + rank_s;
                if (pos_s[3]) begin
                    nxt_s[pos_s[2:0]] = lane_word[64*i +: 64];
                end else begin
                    cur_s[pos_s[2:0]] = lane_word[64*i +: 64];
                end
                rank_s = rank_s + 4'd1;
            end else begin
                rank_s = rank_s;
            end
        end
        sum_s      = {1'b0, fill_q} + rank_s;
        complete_s = sum_s[3];
    end

    // Packer FSM, line push selection and sticky error flags.
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        acc_d       = acc_q;
        push_s      = 1'b0;
        push_line_s = cur_s;
        cnt_d       = cnt_q + 32'(rank_s);
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                acc_d  = complete_s ? nxt_s : cur_s;
                fill_d = sum_s[2:0];
                push_s = complete_s;
                if (last_input_in) begin
                    state_d = (sum_s[2:0] != 3'd0) ? ST_FLUSH : ST_DRAIN;
                end else if (rank_s != 4'd0) begin
                    state_d = ST_ACCUM;
                end else begin
                    state_d = state_q;
                end
            end
            ST_FLUSH: begin
                push_s      = 1'b1;
                push_line_s = pad_line(acc_q, fill_q);
                fill_d      = 3'd0;
                state_d     = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                fill_d  = 3'd0;
            end
        endcase
        pop_s     = out_ready && !fifo_empty_s;
        push_ok_s = push_s && (!fifo_full_s || pop_s);
        err_ov_d  = err_ov_q || (push_s && fifo_full_s && !pop_s);
        err_pr_d  = err_pr_q || ((lane_valid != {LANES{1'b0}}) &&
                    ((state_q == ST_FLUSH) || (state_q == ST_DRAIN) || (state_q == ST_DONE)));
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            fill_q   <= 3'd0;
            acc_q    <= '0;
            cnt_q    <= 32'd0;
            err_ov_q <= 1'b0;
            err_pr_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            err_ov_q <= err_ov_d;
            err_pr_q <= err_pr_d;
            done_q   <= done_d;
        end
    end

    sssp_line_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (512)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_s),
        .wr_data (push_line_s),
        .rd_en   (out_ready),
        .rd_data (out_line),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    assign out_valid    = !fifo_empty_s;
    assign almost_full  = (32'(fifo_count_s) + 32'(AFULL_MARGIN)) >= 32'(FIFO_DEPTH);
    assign done         = done_q;
    assign update_count = cnt_q;
    assign err_overflow = err_ov_q;
    assign err_proto    = err_pr_q;

`ifdef SSSP_PACKER_STATS_EN
    logic [31:0] lines_q, lines_d;
    logic [31:0] pad_q, pad_d;

    // Padding is counted when the flushed line actually enters the FIFO.
    always_comb begin
        lines_d = lines_q + 32'(pop_s);
        if ((state_q == ST_FLUSH) && push_ok_s) begin
            pad_d = pad_q + 32'(4'd8 - {1'b0, fill_q});
        end else begin
            pad_d = pad_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lines_q <= 32'd0;
            pad_q   <= 32'd0;
        end else begin
            lines_q <= lines_d;
            pad_q   <= pad_d;
        end
    end

    assign lines_out = lines_q;
    assign pad_slots = pad_q;
`endif

endmodule

// File: tb/tb_sssp_update_packer.sv
// Self-checking bench for sssp_update_packer: scenario tasks against a queue-based model of
// update packing (append accepted words, cut every 8, pad the remainder on last_input).
module tb_sssp_update_packer;

    logic         clk, rst;
    logic [1:0]   control_in;
    logic [3:0]   lane_valid;
    logic [255:0] lane_word;
    logic         last_input_in;
    logic [511:0] out_line;
    logic         out_valid, out_ready, almost_full, done;
    logic [31:0]  update_count;
    logic         err_overflow, err_proto;
`ifdef SSSP_PACKER_STATS_EN
    logic [31:0]  lines_out, pad_slots;
`endif

    int checks = 0;
    int failures = 0;

    logic [63:0]  pend[$];
    logic [511:0] exp_lines[$];
    int unsigned  m_count;

    sssp_update_packer dut (
        .clk           (clk),
        .rst           (rst),
        .control_in    (control_in),
        .lane_valid    (lane_valid),
        .lane_word     (lane_word),
        .last_input_in (last_input_in),
        .out_line      (out_line),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .almost_full   (almost_full),
        .done          (done),
        .update_count  (update_count),
`ifdef SSSP_PACKER_STATS_EN
        .lines_out     (lines_out),
        .pad_slots     (pad_slots),
`endif
        .err_overflow  (err_overflow),
        .err_proto     (err_proto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void m_reset();
        pend.delete();
        exp_lines.delete();
        m_count = 0;
    endfunction

    function automatic void m_cut_line();
        logic [511:0] ln;
        for (int k = 0; k < 8; k++) ln[64*k +: 64] = pend.pop_front();
        exp_lines.push_back(ln);
    endfunction

    function automatic void m_accept(input logic [3:0] v, input logic [255:0] w, input logic [1:0] c);
        if (c == 2'h2) begin
            for (int i = 0; i < 4; i++) begin
                if (v[i]) begin
                    pend.push_back(w[64*i +: 64]);
                    m_count++;
                end
            end
        end
        while (pend.size() >= 8) m_cut_line();
    endfunction

    function automatic void m_flush();
        if (pend.size() > 0) begin
            while (pend.size() < 8) pend.push_back(64'hFFFF_FFFF_FFFF_FFFF);
            m_cut_line();
        end
    endfunction

    function automatic logic [255:0] rand_words();
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] seq_words(input int base);
        logic [255:0] r;
        for (int i = 0; i < 4; i++) r[64*i +: 64] = {$urandom, 32'(base + i)};
        return r;
    endfunction

    task automatic beat(input logic [3:0] v, input logic [255:0] w, input logic [1:0] c, input logic l);
        lane_valid = v; lane_word = w; control_in = c; last_input_in = l;
        m_accept(v, w, c);
        if (l) m_flush();
        @(posedge clk); #1;
        lane_valid = 4'd0; last_input_in = 1'b0; control_in = 2'h2;
    endtask

    task automatic do_reset();
        rst = 1'b1; out_ready = 1'b0; lane_valid = 4'd0; lane_word = 256'd0;
        last_input_in = 1'b0; control_in = 2'h2;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (out_line !== 512'd0) begin failures++; $display("FAIL reset_out_line: got %h required 0", out_line); end
        checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_almost_full: got %b required 0", almost_full); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b required 0", done); end
        checks++; if (update_count !== 32'd0) begin failures++; $display("FAIL reset_update_count: got %0d required 0", update_count); end
        checks++; if ({err_overflow, err_proto} !== 2'b00) begin failures++; $display("FAIL reset_err_flags: got %b required 00", {err_overflow, err_proto}); end
    endtask

    task automatic test_single_lane();
        logic [511:0] e;
        logic slots_ok;
        logic saw_done;
        do_reset();
        for (int k = 0; k < 8; k++) beat(4'b0001, {192'd0, $urandom, 32'(k)}, 2'h2, 1'b0);
        checks++; if (update_count !== 32'd8) begin failures++; $display("FAIL single_count: got %0d required 8", update_count); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b required 1", out_valid); end
        slots_ok = 1'b1;
        for (int k = 0; k < 8; k++) if (out_line[64*k +: 32] !== 32'(k)) slots_ok = 1'b0;
        checks++; if (!slots_ok) begin failures++; $display("FAIL single_slot_dst: got %h required dst k in slot k", out_line); end
        e = exp_lines.pop_front();
        checks++; if (out_line !== e) begin failures++; $display("FAIL single_line: got %h required %h", out_line, e); end
        saw_done = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (done) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (saw_done !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL single_no_done: got done_seen=%b out_valid=%b required 0 0", saw_done, out_valid); end
    endtask

    task automatic test_full_beats();
        logic [511:0] e;
        logic slots_ok;
        do_reset();
        out_ready = 1'b1;
        beat(4'b1111, seq_words(0), 2'h2, 1'b0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL beats_early_valid: got %b required 0", out_valid); end
        beat(4'b1111, seq_words(4), 2'h2, 1'b0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL beats_latency: got %b required 1", out_valid); end
        slots_ok = 1'b1;
        for (int k = 0; k < 8; k++) if (out_line[64*k +: 32] !== 32'(k)) slots_ok = 1'b0;
        e = exp_lines.pop_front();
        checks++; if (!slots_ok || out_line !== e) begin failures++; $display("FAIL beats_line: got %h required %h", out_line, e); end
    endtask

    task automatic test_flush_padding();
        logic [511:0] e;
        logic early_done, got_done;
        int popped;
        do_reset();
        beat(4'b1111, rand_words(), 2'h2, 1'b0);
        beat(4'b0011, rand_words(), 2'h2, 1'b0);
        beat(4'b1111, rand_words(), 2'h2, 1'b1);
        early_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (done) early_done = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (early_done !== 1'b0) begin failures++; $display("FAIL flush_early_done: got %b required 0", early_done); end
        checks++; if (exp_lines.size() != 2) begin failures++; $display("FAIL flush_model_lines: got %0d required 2", exp_lines.size()); end
        got_done = 1'b0; popped = 0;
        for (int c = 0; c < 20; c++) begin
            out_ready = 1'b1;
            if (done) got_done = 1'b1;
            if (out_valid) begin
                popped++;
                checks++;
                if (exp_lines.size() == 0) begin failures++; $display("FAIL flush_extra_line: got %h required none", out_line); end
                else begin
                    e = exp_lines.pop_front();
                    if (out_line !== e) begin failures++; $display("FAIL flush_line%0d: got %h required %h", popped, out_line, e); end
                end
            end
            @(posedge clk); #1;
        end
        checks++; if (!got_done || popped != 2) begin failures++; $display("FAIL flush_done: got done=%b lines=%0d required 1 2", got_done, popped); end
    endtask

    task automatic test_overflow();
        logic [511:0] e;
        do_reset();
        for (int ln = 1; ln <= 9; ln++) begin
            beat(4'b1111, rand_words(), 2'h2, 1'b0);
            beat(4'b1111, rand_words(), 2'h2, 1'b0);
            if (ln == 5) begin checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL ovf_afull_at5: got %b required 0", almost_full); end end
            if (ln == 6) begin checks++; if (almost_full !== 1'b1) begin failures++; $display("FAIL ovf_afull_at6: got %b required 1", almost_full); end end
            if (ln == 8) begin checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL ovf_early_err: got %b required 0", err_overflow); end end
        end
        checks++; if (err_overflow !== 1'b1) begin failures++; $display("FAIL ovf_err: got %b required 1", err_overflow); end
        void'(exp_lines.pop_back());
        for (int c = 0; c < 8; c++) begin
            out_ready = 1'b1;
            e = exp_lines.pop_front();
            checks++; if (out_valid !== 1'b1 || out_line !== e) begin failures++; $display("FAIL ovf_line%0d: got v=%b %h required %h", c, out_valid, out_line, e); end
            @(posedge clk); #1;
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovf_dropped_line: got out_valid=%b required 0", out_valid); end
    endtask

    task automatic test_ignore_and_reset();
        logic [511:0] e;
        do_reset();
        for (int k = 0; k < 3; k++) beat(4'b0001, rand_words(), 2'h2, 1'b0);
        beat(4'b1010, rand_words(), 2'h1, 1'b0);
        checks++; if (update_count !== 32'd3) begin failures++; $display("FAIL ignore_count: got %0d required 3", update_count); end
        do_reset();
        checks++; if (out_valid !== 1'b0 || update_count !== 32'd0) begin failures++; $display("FAIL midreset_state: got v=%b cnt=%0d required 0 0", out_valid, update_count); end
        beat(4'b1111, rand_words(), 2'h2, 1'b0);
        beat(4'b1111, rand_words(), 2'h2, 1'b0);
        e = exp_lines.pop_front();
        checks++; if (out_valid !== 1'b1 || out_line !== e) begin failures++; $display("FAIL midreset_clean_line: got v=%b %h required %h", out_valid, out_line, e); end
    endtask

    task automatic test_last_alone();
        logic saw_done;
        do_reset();
        beat(4'b0000, 256'd0, 2'h2, 1'b1);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL last_done_t1: got %b required 0", done); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL last_done_t2: got done=%b v=%b required 1 0", done, out_valid); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || err_proto !== 1'b0) begin failures++; $display("FAIL last_done_t3: got done=%b err_proto=%b required 0 0", done, err_proto); end
        beat(4'b0000, 256'd0, 2'h2, 1'b1);
        lane_valid = 4'b0001; lane_word = rand_words(); control_in = 2'h2;
        @(posedge clk); #1;
        lane_valid = 4'b0000;
        checks++; if (err_proto !== 1'b1 || update_count !== 32'd0) begin failures++; $display("FAIL proto_drain: got err=%b cnt=%0d required 1 0", err_proto, update_count); end
        saw_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (saw_done !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL proto_done: got done_seen=%b v=%b required 1 0", saw_done, out_valid); end
    endtask

    task automatic test_random();
        logic [511:0] e;
        logic [3:0] v;
        logic [1:0] c;
        logic got_done;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            v = almost_full ? 4'd0 : 4'($urandom_range(0, 15));
            c = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'h2;
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                checks++;
                if (exp_lines.size() == 0) begin failures++; $display("FAIL rand_extra_line: got %h required none", out_line); end
                else begin
                    e = exp_lines.pop_front();
                    if (out_line !== e) begin failures++; $display("FAIL rand_line: got %h required %h", out_line, e); end
                end
            end
            beat(v, rand_words(), c, cyc == 399);
        end
        got_done = 1'b0;
        for (int cyc = 0; cyc < 40 && !got_done; cyc++) begin
            out_ready = 1'b1;
            if (done) got_done = 1'b1;
            if (out_valid) begin
                checks++;
                if (exp_lines.size() == 0) begin failures++; $display("FAIL rand_drain_extra: got %h required none", out_line); end
                else begin
                    e = exp_lines.pop_front();
                    if (out_line !== e) begin failures++; $display("FAIL rand_drain_line: got %h required %h", out_line, e); end
                end
            end
            @(posedge clk); #1;
        end
        checks++; if (!got_done || exp_lines.size() != 0) begin failures++; $display("FAIL rand_done: got done=%b left=%0d required 1 0", got_done, exp_lines.size()); end
        checks++; if (update_count !== 32'(m_count)) begin failures++; $display("FAIL rand_count: got %0d required %0d", update_count, m_count); end
        checks++; if ({err_overflow, err_proto} !== 2'b00) begin failures++; $display("FAIL rand_errs: got %b required 00", {err_overflow, err_proto}); end
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b0; lane_valid = 4'd0; lane_word = 256'd0;
        last_input_in = 1'b0; control_in = 2'h2;
        test_reset();
        test_single_lane();
        test_full_beats();
        test_flush_padding();
        test_overflow();
        test_ignore_and_reset();
        test_last_alone();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
